// File: rtl/rob_banked.sv
// rob_banked: banked reorder buffer. Each row holds NBANK lanes dispatched together.
// Rows retire in order from the head, and the whole row retires at once.
// Writeback, exception and branch-resolve events update per-entry state.
// An exception at a ready head row flushes the entire buffer on the next edge.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_dis_*                      one-row dispatch (lane valids, pc, uops, branch masks, dest tags)
//   o_dis_tag, o_full, o_empty   allocation status, from registers
//   i_wb_en/i_wb_tag             NWB writeback ports, tag = {row, bank}
//   i_exc_en/i_exc_tag           exception report for one entry
//   i_br_ok/i_br_kill/i_br_mask  branch resolution (one-hot mask bit)
//   o_com_*                      head-row commit, combinational from registers
//   o_exc, o_exc_pc, o_exc_bank  head-row exception, combinational from registers
module rob_banked #(
  parameter  int unsigned NBANK     = 4,
  parameter  int unsigned NROW      = 8,
  parameter  int unsigned WIDTH_REG = 7,
  parameter  int unsigned WIDTH_BRM = 4,
  parameter  int unsigned WIDTH_UOP = 7,
  parameter  int unsigned NWB       = 2,
  localparam int unsigned RW        = $clog2(NROW),
  localparam int unsigned BW        = $clog2(NBANK),
  localparam int unsigned TAG       = RW + BW
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_dis_we,
  input  logic [NBANK-1:0]           i_dis_lane,
  input  logic [31:0]                i_dis_pc,
  input  logic [NBANK*WIDTH_UOP-1:0] i_dis_uops,
  input  logic [NBANK*WIDTH_BRM-1:0] i_dis_mask,
  input  logic [NBANK*WIDTH_REG-1:0] i_dis_prd,
  output logic [RW-1:0]              o_dis_tag,
  output logic                       o_full,
  output logic                       o_empty,
  input  logic [NWB-1:0]             i_wb_en,
  input  logic [NWB*TAG-1:0]         i_wb_tag,
  input  logic                       i_exc_en,
  input  logic [TAG-1:0]             i_exc_tag,
  input  logic                       i_br_ok,
  input  logic                       i_br_kill,
  input  logic [WIDTH_BRM-1:0]       i_br_mask,
  output logic                       o_com_en,
  output logic [NBANK-1:0]           o_com_lane,
  output logic [NBANK*WIDTH_REG-1:0] o_com_prd,
  output logic [31:0]                o_com_pc,
  output logic                       o_exc,
  output logic [31:0]                o_exc_pc,
  output logic [BW-1:0]              o_exc_bank
);

  localparam int unsigned CW = RW + 1;

  // Per-entry control state (reset) and payload (not reset)
  logic [NROW-1:0][NBANK-1:0]                val_q,  val_d;
  logic [NROW-1:0][NBANK-1:0]                busy_q, busy_d;
  logic [NROW-1:0][NBANK-1:0]                exc_q,  exc_d;
  logic [NROW-1:0][NBANK-1:0]                kill_q, kill_d;
  logic [NROW-1:0][NBANK-1:0][WIDTH_UOP-1:0] uop_q,  uop_d;
  logic [NROW-1:0][NBANK-1:0][WIDTH_BRM-1:0] mask_q, mask_d;
  logic [NROW-1:0][NBANK-1:0][WIDTH_REG-1:0] prd_q,  prd_d;
  logic [NROW-1:0][31:0]                     pc_q,   pc_d;

  logic [RW-1:0] head_q,  head_d;
  logic [RW-1:0] tail_q,  tail_d;
  logic [CW-1:0] count_q, count_d;

  // Head-row view
  logic [NBANK-1:0] h_val, h_busy, h_exc, h_kill, h_exc_lanes;
  logic             head_ready;
  logic             com_fire;
  logic             flush;
  logic             dis_acc;

  // Decoded writeback / exception addresses
  logic [RW-1:0] wb_row  [NWB];
  logic [BW-1:0] wb_bank [NWB];
  logic [RW-1:0] exc_row;
  logic [BW-1:0] exc_bank;

  // uops are carried for a future trace/debug port
  logic unused_uop;
  assign unused_uop = ^uop_q;

  for (genvar k = 0; k < NWB; k++) begin : g_wb_dec
    assign wb_row[k]  = i_wb_tag[k*TAG+BW +: RW];
    assign wb_bank[k] = i_wb_tag[k*TAG +: BW];
  end

  assign exc_row  = i_exc_tag[TAG-1:BW];
  assign exc_bank = i_exc_tag[BW-1:0];

  // Status outputs, registers only
  assign o_full    = (count_q == CW'(NROW));
  assign o_empty   = (count_q == '0);
  assign o_dis_tag = tail_q;

  assign h_val       = val_q[head_q];
  assign h_busy      = busy_q[head_q];
  assign h_exc       = exc_q[head_q];
  assign h_kill      = kill_q[head_q];
  assign h_exc_lanes = h_val & h_exc & ~h_kill;

  // Ready once every valid lane has left the busy state (killed lanes included)
  assign head_ready = !o_empty && ((h_val & h_busy) == '0);
  assign com_fire   = !i_rst && head_ready && (h_exc_lanes == '0);
  assign flush      = !i_rst && head_ready && (h_exc_lanes != '0);
  assign dis_acc    = i_dis_we && !o_full;

  // Commit / exception outputs
  assign o_com_en   = com_fire;
  assign o_com_lane = com_fire ? (h_val & ~h_kill) : '0;
  assign o_com_prd  = prd_q[head_q];
  assign o_com_pc   = pc_q[head_q];
  assign o_exc      = flush;
  assign o_exc_pc   = pc_q[head_q];

  // Lowest excepting lane: scan high to low so the lowest set bit wins
  always_comb begin
    o_exc_bank = '0;
    for (int b = int'(NBANK) - 1; b >= 0; b--) begin
      if (h_exc_lanes[b]) o_exc_bank = BW'(b);
    end
  end

  // Next-state: commit, dispatch, writeback, exception, branch, then flush override
  always_comb begin
    val_d   = val_q;
    busy_d  = busy_q;
    exc_d   = exc_q;
    kill_d  = kill_q;
    uop_d   = uop_q;
    mask_d  = mask_q;
    prd_d   = prd_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (com_fire) begin
      val_d[head_q] = '0;
      head_d        = head_q + RW'(1);
    end

    if (dis_acc) begin
      val_d[tail_q]  = i_dis_lane;
      busy_d[tail_q] = '1;
      exc_d[tail_q]  = '0;
      kill_d[tail_q] = '0;
      uop_d[tail_q]  = i_dis_uops;
      mask_d[tail_q] = i_dis_mask;
      prd_d[tail_q]  = i_dis_prd;
      pc_d[tail_q]   = i_dis_pc;
      tail_d         = tail_q + RW'(1);
    end

    unique case ({dis_acc, com_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Writeback only completes live, unkilled entries
    for (int k = 0; k < int'(NWB); k++) begin
      if (i_wb_en[k] && val_q[wb_row[k]][wb_bank[k]] && !kill_q[wb_row[k]][wb_bank[k]]) begin
        busy_d[wb_row[k]][wb_bank[k]] = 1'b0;
      end
    end

    if (i_exc_en && val_q[exc_row][exc_bank]) begin
      exc_d[exc_row][exc_bank]  = 1'b1;
      busy_d[exc_row][exc_bank] = 1'b0;
    end

    // Branch resolution runs last so a kill overrides same-cycle writeback/exception.
    // It sees this cycle's dispatch, so dependent uops arriving now are covered too.
    for (int r = 0; r < int'(NROW); r++) begin
      for (int b = 0; b < int'(NBANK); b++) begin
        if (i_br_kill && val_d[RW'(r)][BW'(b)] &&
            ((mask_d[RW'(r)][BW'(b)] & i_br_mask) != '0)) begin
          kill_d[RW'(r)][BW'(b)] = 1'b1;
          busy_d[RW'(r)][BW'(b)] = 1'b0;
        end
        if (i_br_ok || i_br_kill) begin
          mask_d[RW'(r)][BW'(b)] = mask_d[RW'(r)][BW'(b)] & ~i_br_mask;
        end
      end
    end

    if (flush) begin
      val_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      val_q   <= '0;
      busy_q  <= '0;
      exc_q   <= '0;
      kill_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      val_q   <= val_d;
      busy_q  <= busy_d;
      exc_q   <= exc_d;
      kill_q  <= kill_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload arrays, qualified by val so no reset needed
  always_ff @(posedge i_clk) begin
    uop_q  <= uop_d;
    mask_q <= mask_d;
    prd_q  <= prd_d;
    pc_q   <= pc_d;
  end

endmodule
